cc_completion_builder: RTL and testbench
========================================

CC_COMPLETION_BUILDER -- requirements
Module: cc_completion_builder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, CC tdata width; legal values are 256 and 512.
REQ-002 SHALL have parameter PAYLOAD_DW, default 2, payload DWs per successful completion; legal values are 1 and 2.
REQ-003 SHALL have parameter DESC_DEPTH, default 4, completion descriptor FIFO depth; power of 2, minimum 2.
REQ-004 SHALL have port axis_clk, input, 1 bit, sole clock.
REQ-005 SHALL have port axis_aresetn, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have ports cpl_valid (input, 1) and cpl_ready (output, 1), the completion descriptor handshake.
REQ-007 SHALL have input completion descriptor fields: cpl_tag 8, cpl_req_id 16, cpl_lower_addr 7, cpl_first_be 4, cpl_tc 3, cpl_attr 3, cpl_data 64.
REQ-008 SHALL have ports ur_valid (input, 1) and ur_ready (output, 1), the unsupported-request handshake.
REQ-009 SHALL have input UR fields: ur_tag 8, ur_req_id 16, ur_lower_addr 7, ur_first_be 4, ur_tc 3, ur_attr 3.
REQ-010 SHALL have output ur_done, 1 bit, one-cycle pulse when a UR TLP is accepted downstream.
REQ-011 SHALL have m_axis_cc_tdata (output, DATA_WIDTH), m_axis_cc_tkeep (output, DATA_WIDTH/32), and m_axis_cc_tvalid / m_axis_cc_tlast (outputs, 1 bit each).
REQ-012 SHALL have m_axis_cc_tready, input, 1 bit, and m_axis_cc_tuser, output, 81 bits, tied to 0.

Function
REQ-013 SHALL buffer completion descriptors in a DESC_DEPTH FIFO; cpl_ready = not full. When full, a write is refused even in a cycle with a simultaneous pop.
REQ-014 SHALL hold one UR in a single-entry register; ur_ready = register empty.
REQ-015 SHALL use a two-state FSM, IDLE and SEND. IDLE→SEND when a source is pending. SEND→IDLE on tvalid&tready with no source pending. SEND→SEND (reload) on tvalid&tready with a source pending.
REQ-016 SHALL arbitrate round-robin when both sources are pending. The source not granted last wins. After reset, cpl has priority.
REQ-017 SHALL load the output register on the edge after the FIFO becomes non-empty, so tvalid rises one cycle after the cpl handshake edge. Steady-state throughput is one TLP per cycle.
REQ-018 SHALL keep tdata, tkeep and tlast stable while tvalid=1 and tready=0.
REQ-019 SHALL emit every TLP as a single beat with tlast=1.
REQ-020 SHALL build header DW0 as {byte_count in [28:16], lower_addr in [6:0]}, other bits 0.
REQ-021 SHALL build header DW1 as {req_id in [31:16], status in [13:11], dword_count in [10:0]}.
REQ-022 SHALL build header DW2 as {attr in [30:28], tc in [27:25], tag in [7:0]}, completer ID 0.
REQ-023 SHALL derive byte_count from first_be: 1xx1→4; 01x1 or 1x10→3; 0011, 0110 or 1100→2; single bit set or 0000→1.
REQ-024 SHALL send a successful completion with status 000 and dword_count=PAYLOAD_DW. Payload is in DW3.. (low PAYLOAD_DW DWs of cpl_data), and tkeep has 3+PAYLOAD_DW low bits set.
REQ-025 SHALL send a UR with status 001, dword_count 0, no payload, and tkeep=3'b111.
REQ-026 SHALL drive all tdata and tkeep bits above the TLP to 0.
REQ-027 SHALL pulse ur_done for the single cycle following the UR TLP handshake edge.

Reset
REQ-028 SHALL, while axis_aresetn=0, hold tvalid, tlast, tkeep, tdata and ur_done at 0, the FIFO empty, the UR register empty, the FSM in IDLE, and RR priority on cpl.
REQ-029 SHALL, on reset mid-TLP, drop the TLP with no replay and drive tvalid=0 asynchronously.

Configuration
REQ-030 SHALL, with CC_STATS_EN defined, add outputs cpl_count[15:0] and ur_count[15:0]. Each is a saturating count (stops at 16'hFFFF) of accepted TLPs and resets to 0.
REQ-031 SHALL, without CC_STATS_EN, have no counter ports or logic.

Structure
REQ-032 SHALL place the status codes (SC=000, UR=001), the header field bit positions and the byte_count function in package cc_cpl_pkg.
REQ-033 SHALL implement the descriptor FIFO as sub-module cc_desc_fifo (parameters WIDTH, DEPTH; full/empty flags; pointer wrap modulo DEPTH).

Verification
REQ-034 SHALL verify: single cpl, tag 8'h5A, first_be 4'hF, data 64'h1122334455667788, tready=1 → one beat; DW0[28:16]=4; DW1[10:0]=2; DW3=32'h55667788; tkeep=8'h1F; tlast=1.
REQ-035 SHALL verify: UR, first_be 4'b0110, tag 8'h07 → DW1[13:11]=001; dword_count=0; byte_count=2; tkeep=8'h07; ur_done high exactly one cycle after handshake.
REQ-036 SHALL verify: cpl and UR pending together for 4 TLPs → order cpl, UR, cpl, UR.
REQ-037 SHALL verify: tready=0 for 10 cycles with a TLP pending → tdata, tkeep and tlast unchanged; exactly one handshake when tready rises.
REQ-038 SHALL verify: DESC_DEPTH=4 with 5 back-to-back cpl and tready=0 → cpl_ready=0 after 4 accepted, including during a pop cycle; all 4 emitted in order after release.
REQ-039 SHALL verify: reset asserted while tvalid=1 → tvalid=0 immediately; no stale TLP after release; counters=0 under CC_STATS_EN.

Source files
------------

// File: rtl/cc_cpl_pkg.sv
// Shared definitions for the PCIe completer-completion builder: status codes,
// header field positions, FSM state type, descriptor layout and byte-count helper.
package cc_cpl_pkg;

    // Completion status codes
    localparam logic [2:0] CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR = 3'b001;

    // Header DW0 field positions
    localparam int unsigned DW0_BC_LSB   = 16;
    localparam int unsigned DW0_BC_W     = 13;
    localparam int unsigned DW0_LA_LSB   = 0;
    localparam int unsigned DW0_LA_W     = 7;
    // Header DW1 field positions
    localparam int unsigned DW1_REQ_LSB  = 16;
    localparam int unsigned DW1_REQ_W    = 16;
    localparam int unsigned DW1_ST_LSB   = 11;
    localparam int unsigned DW1_ST_W     = 3;
    localparam int unsigned DW1_DWC_LSB  = 0;
    localparam int unsigned DW1_DWC_W    = 11;
    // Header DW2 field positions
    localparam int unsigned DW2_ATTR_LSB = 28;
    localparam int unsigned DW2_ATTR_W   = 3;
    localparam int unsigned DW2_TC_LSB   = 25;
    localparam int unsigned DW2_TC_W     = 3;
    localparam int unsigned DW2_TAG_LSB  = 0;
    localparam int unsigned DW2_TAG_W    = 8;

    localparam int unsigned HDR_DWS = 3;

    typedef enum logic {
        StIdle,
        StSend
    } cc_state_e;

    // One queued successful-completion request
    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] req_id;
        logic [6:0]  lower_addr;
        logic [3:0]  first_be;
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic [63:0] data;
    } cpl_desc_t;

    // Byte count of a single-DW request from its first byte enables
    function automatic logic [12:0] byte_count(input logic [3:0] first_be);
        logic [12:0] bc;
        casez (first_be)
            4'b1??1:                   bc = 13'd4;
            4'b01?1, 4'b1?10:          bc = 13'd3;
            4'b0011, 4'b0110, 4'b1100: bc = 13'd2;
            default:                   bc = 13'd1;
        endcase
        return bc;
    endfunction

    // Three header DWs packed as {DW2, DW1, DW0}
    function automatic logic [95:0] build_header(
        input logic [6:0]  lower_addr,
        input logic [3:0]  first_be,
        input logic [15:0] req_id,
        input logic [2:0]  status,
        input logic [10:0] dword_count,
        input logic [2:0]  tc,
        input logic [2:0]  attr,
        input logic [7:0]  tag
    );
        logic [31:0] dw0, dw1, dw2;
        dw0 = '0;
        dw1 = '0;
        dw2 = '0;
        dw0[DW0_BC_LSB +: DW0_BC_W]     = byte_count(first_be);
        dw0[DW0_LA_LSB +: DW0_LA_W]     = lower_addr;
        dw1[DW1_REQ_LSB +: DW1_REQ_W]   = req_id;
        dw1[DW1_ST_LSB +: DW1_ST_W]     = status;
        dw1[DW1_DWC_LSB +: DW1_DWC_W]   = dword_count;
        dw2[DW2_ATTR_LSB +: DW2_ATTR_W] = attr;
        dw2[DW2_TC_LSB +: DW2_TC_W]     = tc;
        dw2[DW2_TAG_LSB +: DW2_TAG_W]   = tag;
        return {dw2, dw1, dw0};
    endfunction

endpackage

// File: rtl/cc_desc_fifo.sv
// Completion descriptor FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable; a write is refused whenever full, even if a pop
// happens in the same cycle.
module cc_desc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_fire, rd_fire;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign wr_fire   = wr_en_i && !full_o;
    assign rd_fire   = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (rd_fire) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    // Pointer and storage registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/cc_completion_builder.sv
// Builds single-beat PCIe CC TLPs from queued successful completions and a
// one-entry unsupported-request slot, round-robin between the two.
// Optional feature: define CC_STATS_EN to add saturating cpl_count/ur_count outputs.
module cc_completion_builder
    import cc_cpl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned PAYLOAD_DW = 2,
    parameter int unsigned DESC_DEPTH = 4
) (
    input  logic                    axis_clk,
    input  logic                    axis_aresetn,
    input  logic                    cpl_valid,
    output logic                    cpl_ready,
    input  logic [7:0]              cpl_tag,
    input  logic [15:0]             cpl_req_id,
    input  logic [6:0]              cpl_lower_addr,
    input  logic [3:0]              cpl_first_be,
    input  logic [2:0]              cpl_tc,
    input  logic [2:0]              cpl_attr,
    input  logic [63:0]             cpl_data,
    input  logic                    ur_valid,
    output logic                    ur_ready,
    input  logic [7:0]              ur_tag,
    input  logic [15:0]             ur_req_id,
    input  logic [6:0]              ur_lower_addr,
    input  logic [3:0]              ur_first_be,
    input  logic [2:0]              ur_tc,
    input  logic [2:0]              ur_attr,
    output logic                    ur_done,
`ifdef CC_STATS_EN
    output logic [15:0]             cpl_count,
    output logic [15:0]             ur_count,
`endif
    output logic [DATA_WIDTH-1:0]   m_axis_cc_tdata,
    output logic [DATA_WIDTH/32-1:0] m_axis_cc_tkeep,
    output logic                    m_axis_cc_tvalid,
    output logic                    m_axis_cc_tlast,
    input  logic                    m_axis_cc_tready,
    output logic [80:0]             m_axis_cc_tuser
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 32;

    cc_state_e state_q, state_d;

    cpl_desc_t wr_desc, rd_desc;
    logic      fifo_full, fifo_empty;

    logic      cpl_pend, ur_pend, hs, load, grant_ur;
    logic      prio_ur_q, prio_ur_d;
    logic      cur_is_ur_q, cur_is_ur_d;
    logic      ur_done_q, ur_done_d;

    logic        ur_full_q, ur_full_d;
    logic [7:0]  ur_tag_q, ur_tag_d;
    logic [15:0] ur_req_id_q, ur_req_id_d;
    logic [6:0]  ur_lower_addr_q, ur_lower_addr_d;
    logic [3:0]  ur_first_be_q, ur_first_be_d;
    logic [2:0]  ur_tc_q, ur_tc_d;
    logic [2:0]  ur_attr_q, ur_attr_d;

    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0]     tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;

    assign wr_desc = '{tag: cpl_tag, req_id: cpl_req_id, lower_addr: cpl_lower_addr,
                       first_be: cpl_first_be, tc: cpl_tc, attr: cpl_attr, data: cpl_data};

    cc_desc_fifo #(
        .WIDTH ($bits(cpl_desc_t)),
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk_i     (axis_clk),
        .rst_ni    (axis_aresetn),
        .wr_en_i   (cpl_valid),
        .wr_data_i (wr_desc),
        .rd_en_i   (load && !grant_ur),
        .rd_data_o (rd_desc),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign cpl_ready        = !fifo_full;
    assign ur_ready         = !ur_full_q;
    assign cpl_pend         = !fifo_empty;
    assign ur_pend          = ur_full_q;
    assign m_axis_cc_tvalid = (state_q == StSend);
    assign hs               = m_axis_cc_tvalid && m_axis_cc_tready;
    assign m_axis_cc_tdata  = tdata_q;
    assign m_axis_cc_tkeep  = tkeep_q;
    assign m_axis_cc_tlast  = tlast_q;
    assign m_axis_cc_tuser  = '0;
    assign ur_done          = ur_done_q;

    // FSM next state, output-register load strobe and round-robin grant
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        grant_ur = ur_pend && (!cpl_pend || prio_ur_q);
        unique case (state_q)
            StIdle: begin
                if (cpl_pend || ur_pend) begin
                    state_d = StSend;
                    load    = 1'b1;
                end
            end
            StSend: begin
                if (hs) begin
                    if (cpl_pend || ur_pend) load = 1'b1;
                    else                     state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // UR holding register: capture when empty, release when granted
    always_comb begin
        ur_full_d       = ur_full_q;
        ur_tag_d        = ur_tag_q;
        ur_req_id_d     = ur_req_id_q;
        ur_lower_addr_d = ur_lower_addr_q;
        ur_first_be_d   = ur_first_be_q;
        ur_tc_d         = ur_tc_q;
        ur_attr_d       = ur_attr_q;
        if (ur_valid && !ur_full_q) begin
            ur_full_d       = 1'b1;
            ur_tag_d        = ur_tag;
            ur_req_id_d     = ur_req_id;
            ur_lower_addr_d = ur_lower_addr;
            ur_first_be_d   = ur_first_be;
            ur_tc_d         = ur_tc;
            ur_attr_d       = ur_attr;
        end
        if (load && grant_ur) ur_full_d = 1'b0;
    end

    // Output beat assembly; contents only change on a load, so they hold under backpressure
    always_comb begin
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        cur_is_ur_d = cur_is_ur_q;
        prio_ur_d   = prio_ur_q;
        ur_done_d   = hs && cur_is_ur_q;
        if (load) begin
            tdata_d     = '0;
            tkeep_d     = '0;
            tlast_d     = 1'b1;
            cur_is_ur_d = grant_ur;
            prio_ur_d   = !grant_ur;
            if (grant_ur) begin
                tdata_d[95:0] = build_header(ur_lower_addr_q, ur_first_be_q, ur_req_id_q,
                                             CPL_STATUS_UR, 11'd0, ur_tc_q, ur_attr_q, ur_tag_q);
                tkeep_d[HDR_DWS-1:0] = '1;
            end else begin
                tdata_d[95:0] = build_header(rd_desc.lower_addr, rd_desc.first_be,
                                             rd_desc.req_id, CPL_STATUS_SC, 11'(PAYLOAD_DW),
                                             rd_desc.tc, rd_desc.attr, rd_desc.tag);
                for (int i = 0; i < PAYLOAD_DW; i++) begin
                    tdata_d[32*(HDR_DWS+i) +: 32] = rd_desc.data[32*i +: 32];
                end
                for (int i = 0; i < HDR_DWS + PAYLOAD_DW; i++) tkeep_d[i] = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q         <= StIdle;
            prio_ur_q       <= 1'b0;
            cur_is_ur_q     <= 1'b0;
            ur_done_q       <= 1'b0;
            ur_full_q       <= 1'b0;
            ur_tag_q        <= '0;
            ur_req_id_q     <= '0;
            ur_lower_addr_q <= '0;
            ur_first_be_q   <= '0;
            ur_tc_q         <= '0;
            ur_attr_q       <= '0;
            tdata_q         <= '0;
            tkeep_q         <= '0;
            tlast_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            prio_ur_q       <= prio_ur_d;
            cur_is_ur_q     <= cur_is_ur_d;
            ur_done_q       <= ur_done_d;
            ur_full_q       <= ur_full_d;
            ur_tag_q        <= ur_tag_d;
            ur_req_id_q     <= ur_req_id_d;
            ur_lower_addr_q <= ur_lower_addr_d;
            ur_first_be_q   <= ur_first_be_d;
            ur_tc_q         <= ur_tc_d;
            ur_attr_q       <= ur_attr_d;
            tdata_q         <= tdata_d;
            tkeep_q         <= tkeep_d;
            tlast_q         <= tlast_d;
        end
    end

`ifdef CC_STATS_EN
    logic [15:0] cpl_count_q, cpl_count_d;
    logic [15:0] ur_count_q, ur_count_d;

    assign cpl_count = cpl_count_q;
    assign ur_count  = ur_count_q;

    // Saturating counts of TLPs accepted downstream
    always_comb begin
        cpl_count_d = cpl_count_q;
        ur_count_d  = ur_count_q;
        if (hs && !cur_is_ur_q && cpl_count_q != 16'hFFFF) cpl_count_d = cpl_count_q + 16'd1;
        if (hs && cur_is_ur_q && ur_count_q != 16'hFFFF)   ur_count_d  = ur_count_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            cpl_count_q <= '0;
            ur_count_q  <= '0;
        end else begin
            cpl_count_q <= cpl_count_d;
            ur_count_q  <= ur_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_cc_completion_builder.sv
// Directed bench for cc_completion_builder (default parameters).
module tb_cc_completion_builder;
    logic         axis_clk = 1'b0;
    logic         axis_aresetn;
    logic         cpl_valid;
    logic         cpl_ready;
    logic [7:0]   cpl_tag;
    logic [15:0]  cpl_req_id;
    logic [6:0]   cpl_lower_addr;
    logic [3:0]   cpl_first_be;
    logic [2:0]   cpl_tc;
    logic [2:0]   cpl_attr;
    logic [63:0]  cpl_data;
    logic         ur_valid;
    logic         ur_ready;
    logic [7:0]   ur_tag;
    logic [15:0]  ur_req_id;
    logic [6:0]   ur_lower_addr;
    logic [3:0]   ur_first_be;
    logic [2:0]   ur_tc;
    logic [2:0]   ur_attr;
    logic         ur_done;
    logic [255:0] tdata;
    logic [7:0]   tkeep;
    logic         tvalid;
    logic         tlast;
    logic         tready;
    logic [80:0]  tuser;
`ifdef CC_STATS_EN
    logic [15:0]  cpl_count;
    logic [15:0]  ur_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mon_tag[$];
    logic [2:0] mon_st[$];

    always #5 axis_clk = ~axis_clk;

    cc_completion_builder dut (
        .axis_clk         (axis_clk),
        .axis_aresetn     (axis_aresetn),
        .cpl_valid        (cpl_valid),
        .cpl_ready        (cpl_ready),
        .cpl_tag          (cpl_tag),
        .cpl_req_id       (cpl_req_id),
        .cpl_lower_addr   (cpl_lower_addr),
        .cpl_first_be     (cpl_first_be),
        .cpl_tc           (cpl_tc),
        .cpl_attr         (cpl_attr),
        .cpl_data         (cpl_data),
        .ur_valid         (ur_valid),
        .ur_ready         (ur_ready),
        .ur_tag           (ur_tag),
        .ur_req_id        (ur_req_id),
        .ur_lower_addr    (ur_lower_addr),
        .ur_first_be      (ur_first_be),
        .ur_tc            (ur_tc),
        .ur_attr          (ur_attr),
        .ur_done          (ur_done),
`ifdef CC_STATS_EN
        .cpl_count        (cpl_count),
        .ur_count         (ur_count),
`endif
        .m_axis_cc_tdata  (tdata),
        .m_axis_cc_tkeep  (tkeep),
        .m_axis_cc_tvalid (tvalid),
        .m_axis_cc_tlast  (tlast),
        .m_axis_cc_tready (tready),
        .m_axis_cc_tuser  (tuser)
    );

    // Log tag and status of every accepted beat
    always @(posedge axis_clk) begin
        if (axis_aresetn && tvalid && tready) begin
            mon_tag.push_back(tdata[71:64]);
            mon_st.push_back(tdata[45:43]);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpl_valid = 0; cpl_tag = 0; cpl_req_id = 0; cpl_lower_addr = 0; cpl_first_be = 0;
        cpl_tc = 0; cpl_attr = 0; cpl_data = 0;
        ur_valid = 0; ur_tag = 0; ur_req_id = 0; ur_lower_addr = 0; ur_first_be = 0;
        ur_tc = 0; ur_attr = 0;
    endtask

    logic [255:0] hold_data;
    logic [7:0]   hold_keep;
    logic         hold_last;
    int           base;

    initial begin
        axis_aresetn = 1'b0;
        tready = 1'b0;
        idle_inputs();
        step(); step();

        // Reset state
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_ur_done", ur_done, 0);
        chk("rst_cpl_ready", cpl_ready, 1);
        chk("rst_ur_ready", ur_ready, 1);
        chk("rst_tuser", tuser, 0);
        #3 axis_aresetn = 1'b1;
        step();

        // Single successful completion
        tready = 1'b1;
        cpl_valid = 1; cpl_tag = 8'h5A; cpl_req_id = 16'hABCD; cpl_lower_addr = 7'h10;
        cpl_first_be = 4'hF; cpl_data = 64'h1122334455667788;
        step();
        idle_inputs();
        chk("cpl_latency_tvalid0", tvalid, 0);
        step();
        chk("cpl_tvalid", tvalid, 1);
        chk("cpl_bc", tdata[28:16], 4);
        chk("cpl_dwc", tdata[42:32], 2);
        chk("cpl_dw3", tdata[127:96], 32'h55667788);
        chk("cpl_tdata", tdata, {96'h0, 32'h11223344, 32'h55667788, 32'h0000005A,
                                 32'hABCD0002, 32'h00040010});
        chk("cpl_tkeep", tkeep, 8'h1F);
        chk("cpl_tlast", tlast, 1);
        step();
        chk("cpl_done_tvalid", tvalid, 0);
        chk("cpl_no_ur_done", ur_done, 0);

        // Unsupported request
        ur_valid = 1; ur_tag = 8'h07; ur_req_id = 16'h1234; ur_lower_addr = 7'h05;
        ur_first_be = 4'b0110; ur_tc = 3'd2; ur_attr = 3'd1;
        step();
        idle_inputs();
        chk("ur_ready_busy", ur_ready, 0);
        step();
        chk("ur_tvalid", tvalid, 1);
        chk("ur_status", tdata[45:43], 3'b001);
        chk("ur_dwc", tdata[42:32], 0);
        chk("ur_bc", tdata[28:16], 2);
        chk("ur_tdata", tdata, {160'h0, 32'h14000007, 32'h12340800, 32'h00020005});
        chk("ur_tkeep", tkeep, 8'h07);
        chk("ur_done_early", ur_done, 0);
        step();
        chk("ur_done_pulse", ur_done, 1);
        step();
        chk("ur_done_single", ur_done, 0);

        // Backpressure holds the beat
        tready = 1'b0;
        cpl_valid = 1; cpl_tag = 8'h33; cpl_first_be = 4'b0001; cpl_data = 64'hDEADBEEFCAFEF00D;
        step();
        idle_inputs();
        step();
        chk("bp_tvalid", tvalid, 1);
        chk("bp_bc", tdata[28:16], 1);
        chk("bp_payload", tdata[159:96], 64'hDEADBEEFCAFEF00D);
        hold_data = tdata; hold_keep = tkeep; hold_last = tlast;
        base = mon_tag.size();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_tdata", tdata, hold_data);
            chk("bp_hold_tkeep", tkeep, hold_keep);
            chk("bp_hold_tlast", tlast, hold_last);
        end
        tready = 1'b1;
        step();
        chk("bp_one_hs", mon_tag.size(), base + 1);
        step(); step(); step();
        chk("bp_still_one_hs", mon_tag.size(), base + 1);

        // Round-robin after a fresh reset
        #2 axis_aresetn = 1'b0;
        tready = 1'b0;
        step();
        #3 axis_aresetn = 1'b1;
        step();
        base = mon_tag.size();
        cpl_valid = 1; cpl_tag = 8'hA1;
        ur_valid = 1; ur_tag = 8'hB1;
        step();
        ur_valid = 0; cpl_tag = 8'hA2;
        step();
        cpl_valid = 0;
        ur_valid = 1; ur_tag = 8'hB2;
        tready = 1'b1;
        step();
        step();
        ur_valid = 0;
        step(); step(); step(); step();
        chk("rr_count", mon_tag.size(), base + 4);
        if (mon_tag.size() >= base + 4) begin
            chk("rr_tag0", mon_tag[base],   8'hA1);
            chk("rr_tag1", mon_tag[base+1], 8'hB1);
            chk("rr_tag2", mon_tag[base+2], 8'hA2);
            chk("rr_tag3", mon_tag[base+3], 8'hB2);
            chk("rr_st0", mon_st[base],   3'b000);
            chk("rr_st1", mon_st[base+1], 3'b001);
            chk("rr_st2", mon_st[base+2], 3'b000);
            chk("rr_st3", mon_st[base+3], 3'b001);
        end

        // FIFO full: one TLP parked in the output register, then 5 back-to-back
        tready = 1'b0;
        base = mon_tag.size();
        cpl_valid = 1; cpl_tag = 8'h10;
        step();
        cpl_valid = 0;
        step();
        for (int i = 1; i <= 5; i++) begin
            cpl_valid = 1; cpl_tag = 8'(i);
            chk("full_cpl_ready", cpl_ready, (i <= 4) ? 1 : 0);
            step();
        end
        chk("full_hold", cpl_ready, 0);
        tready = 1'b1;
        #1;
        chk("full_pop_cycle", cpl_ready, 0);
        step();
        cpl_valid = 0;
        for (int i = 0; i < 8; i++) step();
        chk("full_count", mon_tag.size(), base + 5);
        if (mon_tag.size() >= base + 5) begin
            chk("full_ord0", mon_tag[base],   8'h10);
            chk("full_ord1", mon_tag[base+1], 8'h01);
            chk("full_ord2", mon_tag[base+2], 8'h02);
            chk("full_ord3", mon_tag[base+3], 8'h03);
            chk("full_ord4", mon_tag[base+4], 8'h04);
        end

        // Reset in the middle of a pending TLP
        tready = 1'b0;
        cpl_valid = 1; cpl_tag = 8'h77;
        step();
        cpl_valid = 0;
        step();
        chk("mid_tvalid_before", tvalid, 1);
`ifdef CC_STATS_EN
        chk("stat_cpl", cpl_count, 16'd7);
        chk("stat_ur", ur_count, 16'd2);
`endif
        #2 axis_aresetn = 1'b0;
        #1;
        chk("mid_tvalid_async", tvalid, 0);
        chk("mid_tdata", tdata, 0);
        chk("mid_tkeep", tkeep, 0);
        chk("mid_tlast", tlast, 0);
`ifdef CC_STATS_EN
        chk("stat_cpl_rst", cpl_count, 0);
        chk("stat_ur_rst", ur_count, 0);
`endif
        step();
        #3 axis_aresetn = 1'b1;
        tready = 1'b1;
        base = mon_tag.size();
        for (int i = 0; i < 5; i++) step();
        chk("mid_no_replay", mon_tag.size(), base);
        chk("mid_tvalid_after", tvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
